// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory request/response port among NUM_REQ requesters.
// One transaction in flight at a time; the response is routed back to the granted owner.
module dmem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 32,
  parameter int WDATA_W    = 32,
  parameter int LINE_W     = 128,
  parameter int FIXED_PRIO = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0]           req_we_i,
  input  logic [NUM_REQ*WDATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [ADDR_W-1:0]            rsp_addr_o,
  output logic [LINE_W-1:0]            rsp_data_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic                         mem_we_o,
  output logic [WDATA_W-1:0]           mem_wdata_o,
  input  logic                         mem_rsp_valid_i,
  output logic                         mem_rsp_ready_o,
  input  logic [ADDR_W-1:0]            mem_rsp_addr_i,
  input  logic [LINE_W-1:0]            mem_rsp_data_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         stray_rsp_o
);

  // state    | meaning
  // IDLE     | arbitrate; winner offered combinationally this cycle
  // OFFER    | request presented, not yet accepted; grant locked to owner
  // WAIT_RSP | one request outstanding; response routed to owner

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    WAIT_RSP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q;
  logic [CNT_W-1:0]   starve_q;
  logic               stray_q;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   mux_idx;
  logic               any_valid;
  logic               others_valid;
  logic               req_hs;

  function automatic logic [IDX_W-1:0] fixed_pick(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) pick = i[IDX_W-1:0];
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && v[idx]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_valid    = |req_valid_i;
  assign others_valid = |req_valid_i[NUM_REQ-1:1];

  // Requester 0 is masked once it has starved the others; it still wins when alone.
  always_comb begin
    logic [NUM_REQ-1:0] cand;
    cand = req_valid_i;
    sel  = '0;
    if (FIXED_PRIO != 0) begin
      if (starve_q == STARVE_MAX && others_valid) cand[0] = 1'b0;
      sel = fixed_pick(cand);
    end else begin
      sel = rr_pick(req_valid_i, rr_q);
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    mux_idx         = owner_q;
    mem_req_valid_o = 1'b0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    mem_rsp_ready_o = 1'b1;
    req_hs          = 1'b0;
    case (state_q)
      IDLE: begin
        mux_idx = sel;
        if (any_valid) begin
          mem_req_valid_o  = 1'b1;
          req_ready_o[sel] = mem_req_ready_i;
          owner_d          = sel;
          req_hs           = mem_req_ready_i;
          state_d          = mem_req_ready_i ? WAIT_RSP : OFFER;
        end
      end
      OFFER: begin
        if (req_valid_i[owner_q]) begin
          mem_req_valid_o      = 1'b1;
          req_ready_o[owner_q] = mem_req_ready_i;
          req_hs               = mem_req_ready_i;
          if (mem_req_ready_i) state_d = WAIT_RSP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        rsp_valid_o[owner_q] = mem_rsp_valid_i;
        mem_rsp_ready_o      = rsp_ready_i[owner_q];
        if (mem_rsp_valid_i && rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      mem_req_valid_o = 1'b0;
      req_ready_o     = '0;
      rsp_valid_o     = '0;
      mem_rsp_ready_o = 1'b1;
      req_hs          = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      starve_q <= '0;
      stray_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (mem_rsp_valid_i && state_q != WAIT_RSP) stray_q <= 1'b1;
      if (req_hs) begin
        if (FIXED_PRIO != 0) begin
          if (owner_d != '0) begin
            starve_q <= '0;
          end else if (others_valid && starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 1'b1;
          end
        end else begin
          rr_q <= (owner_d == LAST_IDX) ? '0 : owner_d + 1'b1;
        end
      end
    end
  end

  assign mem_addr_o  = req_addr_i[int'(mux_idx) * ADDR_W +: ADDR_W];
  assign mem_wdata_o = req_wdata_i[int'(mux_idx) * WDATA_W +: WDATA_W];
  assign mem_we_o    = req_we_i[mux_idx];
  assign rsp_addr_o  = mem_rsp_addr_i;
  assign rsp_data_o  = mem_rsp_data_i;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;
  assign stray_rsp_o = stray_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a fixed-priority 2-requester instance and a
// round-robin 3-requester instance, checked against a transaction-level model.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int LIM = 2;

  // fixed-priority instance (a_*)
  logic [1:0]   a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [63:0]  a_req_addr, a_req_wdata;
  logic [31:0]  a_rsp_addr, a_mem_addr, a_mem_wdata, a_mem_rsp_addr;
  logic [127:0] a_rsp_data, a_mem_rsp_data;
  logic         a_mem_req_valid, a_mem_req_ready, a_mem_we, a_mem_rsp_valid, a_mem_rsp_ready;
  logic         a_busy, a_stray;
  logic [0:0]   a_owner;

  // round-robin instance (b_*)
  logic [2:0]   b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [95:0]  b_req_addr, b_req_wdata;
  logic [31:0]  b_rsp_addr, b_mem_addr, b_mem_wdata, b_mem_rsp_addr;
  logic [127:0] b_rsp_data, b_mem_rsp_data;
  logic         b_mem_req_valid, b_mem_req_ready, b_mem_we, b_mem_rsp_valid, b_mem_rsp_ready;
  logic         b_busy, b_stray;
  logic [1:0]   b_owner;

  dmem_port_arbiter #(.NUM_REQ(2), .FIXED_PRIO(1), .STARVE_LIM(LIM)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_we_i(a_req_we), .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_addr_o(a_rsp_addr), .rsp_data_o(a_rsp_data),
    .mem_req_valid_o(a_mem_req_valid), .mem_req_ready_i(a_mem_req_ready),
    .mem_addr_o(a_mem_addr), .mem_we_o(a_mem_we), .mem_wdata_o(a_mem_wdata),
    .mem_rsp_valid_i(a_mem_rsp_valid), .mem_rsp_ready_o(a_mem_rsp_ready),
    .mem_rsp_addr_i(a_mem_rsp_addr), .mem_rsp_data_i(a_mem_rsp_data),
    .busy_o(a_busy), .owner_o(a_owner), .stray_rsp_o(a_stray)
  );

  dmem_port_arbiter #(.NUM_REQ(3), .FIXED_PRIO(0), .STARVE_LIM(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_we_i(b_req_we), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_addr_o(b_rsp_addr), .rsp_data_o(b_rsp_data),
    .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(b_mem_req_ready),
    .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we), .mem_wdata_o(b_mem_wdata),
    .mem_rsp_valid_i(b_mem_rsp_valid), .mem_rsp_ready_o(b_mem_rsp_ready),
    .mem_rsp_addr_i(b_mem_rsp_addr), .mem_rsp_data_i(b_mem_rsp_data),
    .busy_o(b_busy), .owner_o(b_owner), .stray_rsp_o(b_stray)
  );

  task automatic clear_inputs();
    a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 2'b11;
    a_mem_req_ready = 1'b0; a_mem_rsp_valid = 1'b0; a_mem_rsp_addr = '0; a_mem_rsp_data = '0;
    b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 3'b111;
    b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b0; b_mem_rsp_addr = '0; b_mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Full transaction on the fixed-priority instance; returns what was observed.
  task automatic run_a(input logic [1:0] vld, input logic [63:0] addr, input logic [63:0] wdata,
                       input int rdy_dly, input int lat, input logic [127:0] data,
                       output int gnt, output int hs_cyc, output logic [31:0] addr_seen,
                       output logic [31:0] wd_seen, output logic [1:0] rspv_seen,
                       output logic [127:0] data_seen);
    gnt = -1; hs_cyc = -1; addr_seen = '0; wd_seen = '0; rspv_seen = '0; data_seen = '0;
    a_req_valid = vld; a_req_addr = addr; a_req_wdata = wdata;
    for (int c = 0; c < 20 && hs_cyc < 0; c++) begin
      a_mem_req_ready = (c >= rdy_dly);
      @(negedge clk);
      if (a_mem_req_valid && a_mem_req_ready) begin
        hs_cyc = c; gnt = -2;
        for (int i = 0; i < 2; i++) if (a_req_ready[i]) gnt = i;
        addr_seen = a_mem_addr; wd_seen = a_mem_wdata;
      end
      @(posedge clk); #1;
    end
    a_req_valid = '0; a_mem_req_ready = 1'b0;
    if (hs_cyc < 0) return;
    for (int c = 0; c < lat; c++) begin @(posedge clk); #1; end
    a_mem_rsp_valid = 1'b1; a_mem_rsp_data = data; a_mem_rsp_addr = addr_seen;
    @(negedge clk);
    rspv_seen = a_rsp_valid; data_seen = a_rsp_data;
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b0;
  endtask

  task automatic run_b(input logic [2:0] vld, input logic [95:0] addr, input logic [95:0] wdata,
                       input int rdy_dly, input int lat, input logic [127:0] data,
                       output int gnt, output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                       output logic [2:0] rspv_seen, output logic [127:0] data_seen);
    int hs_cyc;
    gnt = -1; hs_cyc = -1; addr_seen = '0; wd_seen = '0; rspv_seen = '0; data_seen = '0;
    b_req_valid = vld; b_req_addr = addr; b_req_wdata = wdata;
    for (int c = 0; c < 20 && hs_cyc < 0; c++) begin
      b_mem_req_ready = (c >= rdy_dly);
      @(negedge clk);
      if (b_mem_req_valid && b_mem_req_ready) begin
        hs_cyc = c; gnt = -2;
        for (int i = 0; i < 3; i++) if (b_req_ready[i]) gnt = i;
        addr_seen = b_mem_addr; wd_seen = b_mem_wdata;
      end
      @(posedge clk); #1;
    end
    b_req_valid = '0; b_mem_req_ready = 1'b0;
    if (hs_cyc < 0) return;
    for (int c = 0; c < lat; c++) begin @(posedge clk); #1; end
    b_mem_rsp_valid = 1'b1; b_mem_rsp_data = data; b_mem_rsp_addr = addr_seen;
    @(negedge clk);
    rspv_seen = b_rsp_valid; data_seen = b_rsp_data;
    @(posedge clk); #1;
    b_mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    a_req_valid = 2'b11; a_mem_req_ready = 1'b1; a_mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({a_mem_req_valid, a_req_ready, a_rsp_valid, a_mem_rsp_ready} !== 6'b0_00_00_1) begin
      bad++;
      $display("FAIL reset_outputs: got mrv=%b rr=%b rv=%b mrr=%b want 0 00 00 1",
               a_mem_req_valid, a_req_ready, a_rsp_valid, a_mem_rsp_ready);
    end
    clear_inputs();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_busy, a_owner, a_stray, b_busy, b_owner, b_stray} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got a busy/owner/stray=%b%b%b b=%b%b%b want all 0",
               a_busy, a_owner, a_stray, b_busy, b_owner, b_stray);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int gnt, hs; logic [31:0] ad, wd; logic [1:0] rv; logic [127:0] dt;
    do_reset();
    run_a(2'b10, {32'h0000_0100, 32'h0000_0040}, {32'h1111_2222, 32'h3333_4444},
          0, 2, {16{8'hAA}}, gnt, hs, ad, wd, rv, dt);
    total++;
    if (gnt !== 1 || hs !== 0) begin
      bad++; $display("FAIL single_grant: got gnt=%0d cyc=%0d want gnt=1 cyc=0", gnt, hs);
    end
    total++;
    if (ad !== 32'h100 || wd !== 32'h1111_2222) begin
      bad++; $display("FAIL single_payload: got addr=%h wdata=%h want 100 11112222", ad, wd);
    end
    total++;
    if (rv !== 2'b10 || dt !== {16{8'hAA}}) begin
      bad++; $display("FAIL single_rsp: got rv=%b data=%h want 10 aa..", rv, dt);
    end
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin
      bad++; $display("FAIL single_busy: got %b want 0", a_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    do_reset();
    a_req_addr = {32'h0000_0100, 32'h0000_0040};
    a_req_valid = 2'b10; a_mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) a_req_valid = 2'b11;
      @(negedge clk);
      total++;
      if (a_mem_req_valid !== 1'b1 || a_mem_addr !== 32'h100 || a_req_ready !== 2'b00) begin
        bad++;
        $display("FAIL lock_offer c%0d: got v=%b addr=%h rdy=%b want 1 100 00",
                 c, a_mem_req_valid, a_mem_addr, a_req_ready);
      end
      @(posedge clk); #1;
    end
    a_mem_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (a_req_ready !== 2'b10) begin
      bad++; $display("FAIL lock_accept: got %b want 10", a_req_ready);
    end
    @(posedge clk); #1;
    a_req_valid = 2'b01;
    @(negedge clk);
    total++;
    if (a_mem_req_valid !== 1'b0 || a_busy !== 1'b1) begin
      bad++; $display("FAIL lock_wait: got v=%b busy=%b want 0 1", a_mem_req_valid, a_busy);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_valid !== 2'b10 || a_mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL lock_rsp: got rv=%b v=%b want 10 0", a_rsp_valid, a_mem_req_valid);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (a_mem_req_valid !== 1'b1 || a_mem_addr !== 32'h40 || a_req_ready !== 2'b01) begin
      bad++;
      $display("FAIL lock_next: got v=%b addr=%h rdy=%b want 1 40 01",
               a_mem_req_valid, a_mem_addr, a_req_ready);
    end
    @(posedge clk); #1;
    a_req_valid = '0; a_mem_req_ready = 1'b0; a_mem_rsp_valid = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_valid !== 2'b01) begin
      bad++; $display("FAIL lock_rsp0: got %b want 01", a_rsp_valid);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b0;
  endtask

  task automatic test_starve();
    int exp_order[6] = '{0, 0, 1, 0, 0, 1};
    int gnt, hs; logic [31:0] ad, wd; logic [1:0] rv; logic [127:0] dt;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      run_a(2'b11, {32'h200, 32'h300}, '0, 0, $urandom_range(0, 2), '0, gnt, hs, ad, wd, rv, dt);
      total++;
      if (gnt !== exp_order[t]) begin
        bad++; $display("FAIL starve_order t%0d: got %0d want %0d", t, gnt, exp_order[t]);
      end
    end
  endtask

  task automatic test_stray();
    int gnt, hs; logic [31:0] ad, wd; logic [1:0] rv; logic [127:0] dt;
    do_reset();
    a_mem_rsp_valid = 1'b1; a_mem_rsp_data = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    total++;
    if (a_mem_rsp_ready !== 1'b1 || a_rsp_valid !== 2'b00) begin
      bad++; $display("FAIL stray_drop: got mrr=%b rv=%b want 1 00", a_mem_rsp_ready, a_rsp_valid);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_a(2'b01, {32'h0, 32'h80}, '0, 1, 1, {4{32'h5}}, gnt, hs, ad, wd, rv, dt);
    @(negedge clk);
    total++;
    if (a_stray !== 1'b1) begin
      bad++; $display("FAIL stray_sticky: got %b want 1", a_stray);
    end
    do_reset();
    @(negedge clk);
    total++;
    if (a_stray !== 1'b0) begin
      bad++; $display("FAIL stray_clear: got %b want 0", a_stray);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req_addr = {32'h0, 32'hC0}; a_req_valid = 2'b01; a_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    a_req_valid = '0; a_mem_req_ready = 1'b0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy: got %b want 1", a_busy);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_stray !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got busy=%b stray=%b want 0 0", a_busy, a_stray);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_valid !== 2'b00) begin
      bad++; $display("FAIL mid_late_rsp: got %b want 00", a_rsp_valid);
    end
    @(posedge clk); #1;
    a_mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (a_stray !== 1'b1) begin
      bad++; $display("FAIL mid_stray: got %b want 1", a_stray);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_fixed();
    int cnt, w, gnt, hs; logic [1:0] v, ev;
    logic [63:0] addr, wdata; logic [127:0] data, dt; logic [31:0] ad, wd; logic [1:0] rv;
    do_reset();
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      v = 2'($urandom_range(1, 3));
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom};
      // lowest valid wins unless requester 0 has used up its streak while 1 waits
      w = (v[0] && !(v[1] && cnt >= LIM)) ? 0 : 1;
      if (w == 0 && v[1]) cnt = (cnt + 1 > LIM) ? LIM : cnt + 1;
      else if (w == 1) cnt = 0;
      ev = '0; ev[w] = 1'b1;
      run_a(v, addr, wdata, $urandom_range(0, 2), $urandom_range(0, 3), data, gnt, hs, ad, wd, rv, dt);
      total++;
      if (gnt !== w || ad !== addr[w*32 +: 32] || wd !== wdata[w*32 +: 32]
          || rv !== ev || dt !== data) begin
        bad++;
        $display("FAIL rand_fixed t%0d: got gnt=%0d addr=%h rv=%b want gnt=%0d addr=%h rv=%b",
                 t, gnt, ad, rv, w, addr[w*32 +: 32], ev);
      end
    end
  endtask

  task automatic test_rr_order();
    int exp_order[4] = '{0, 1, 2, 0};
    int gnt; logic [31:0] ad, wd; logic [2:0] rv; logic [127:0] dt;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      run_b(3'b111, {32'h30, 32'h20, 32'h10}, '0, 0, 1, '0, gnt, ad, wd, rv, dt);
      total++;
      if (gnt !== exp_order[t]) begin
        bad++; $display("FAIL rr_order t%0d: got %0d want %0d", t, gnt, exp_order[t]);
      end
    end
  endtask

  task automatic test_random_rr();
    int rr, w, gnt; logic [2:0] v, ev, rv;
    logic [95:0] addr, wdata; logic [127:0] data, dt; logic [31:0] ad, wd;
    do_reset();
    rr = 0;
    for (int t = 0; t < 40; t++) begin
      v = 3'($urandom_range(1, 7));
      addr = {$urandom, $urandom, $urandom}; wdata = {$urandom, $urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom};
      w = -1;
      for (int k = 0; k < 3; k++) if (w < 0 && v[(rr + k) % 3]) w = (rr + k) % 3;
      rr = (w + 1) % 3;
      ev = '0; ev[w] = 1'b1;
      run_b(v, addr, wdata, $urandom_range(0, 2), $urandom_range(0, 3), data, gnt, ad, wd, rv, dt);
      total++;
      if (gnt !== w || ad !== addr[w*32 +: 32] || wd !== wdata[w*32 +: 32]
          || rv !== ev || dt !== data) begin
        bad++;
        $display("FAIL rand_rr t%0d: got gnt=%0d addr=%h rv=%b want gnt=%0d addr=%h rv=%b",
                 t, gnt, ad, rv, w, addr[w*32 +: 32], ev);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_lock();
    test_starve();
    test_stray();
    test_reset_mid();
    test_random_fixed();
    test_rr_order();
    test_random_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
